// File: rtl/rx_pkg.sv
// rx_pkg: shared types and default constants for the UART receive control unit.
//   rx_state_t      - receive FSM state encoding
//   RX_CLKS_PER_BIT - default clock cycles per serial bit (even, >= 4)
//   RX_DATA_BITS    - default data bits per frame
package rx_pkg;

  localparam int unsigned RX_CLKS_PER_BIT = 10;
  localparam int unsigned RX_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    RECV,
    STOP_CHK,
    LOAD
  } rx_state_t;

endpackage

// File: rtl/rx_ctrl_unit_if.sv
// rx_ctrl_unit_if: serial/host-side signal bundle of the receive control unit.
//   serial_in     - raw asynchronous serial line, idle high
//   stop_bit      - stop-bit output of the receive shift register
//   data_read     - host consumed the receive buffer (one-cycle pulse)
//   shift_strobe  - one-cycle shift enable to the shift register
//   load_buffer   - one-cycle pulse copying packet data into the receive buffer
//   data_ready    - buffer holds unread data
//   framing_error - last frame had a zero stop bit
//   overrun_error - a frame was loaded while data_ready was still set
// Modports: master = environment side, slave = receive control unit.
interface rx_ctrl_unit_if;

  logic serial_in;
  logic stop_bit;
  logic data_read;
  logic shift_strobe;
  logic load_buffer;
  logic data_ready;
  logic framing_error;
  logic overrun_error;

  modport master (
    output serial_in,
    output stop_bit,
    output data_read,
    input  shift_strobe,
    input  load_buffer,
    input  data_ready,
    input  framing_error,
    input  overrun_error
  );

  modport slave (
    input  serial_in,
    input  stop_bit,
    input  data_read,
    output shift_strobe,
    output load_buffer,
    output data_ready,
    output framing_error,
    output overrun_error
  );

endinterface

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: bit-period timer and bit counter for the receive control unit.
//   clk, n_rst   - clock and synchronous active-low reset
//   enable       - count while high
//   clear        - zero timer and bit counter (takes priority over enable)
//   shift_strobe - high while enabled on the last tick of a bit period
//   frame_done   - the current strobe is the last one of the frame
//   half_bit     - timer sits at the half-bit sample point
module rx_bit_timer
  import rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = RX_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = RX_DATA_BITS
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic clear,
  output logic shift_strobe,
  output logic frame_done,
  output logic half_bit
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 2);

  localparam logic [TW-1:0] LastTick = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HalfTick = TW'(CLKS_PER_BIT / 2 - 1);
  // Counter value just before the strobe that completes DATA_BITS+1 shifts.
  localparam logic [BW-1:0] LastBit  = BW'(DATA_BITS);

  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          wrap;

  assign wrap         = (timer_q == LastTick);
  assign shift_strobe = enable & wrap;
  assign frame_done   = shift_strobe & (bit_cnt_q == LastBit);
  assign half_bit     = (timer_q == HalfTick);

  always_comb begin
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    if (clear) begin
      timer_d   = '0;
      bit_cnt_d = '0;
    end else if (enable) begin
      if (wrap) begin
        timer_d   = '0;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        timer_d   = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      timer_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/rx_ctrl_unit.sv
// rx_ctrl_unit: UART receive control. Synchronizes the serial line, detects and
// qualifies the start bit, issues mid-bit shift strobes, checks the stop bit,
// loads the receive buffer and keeps the host status flags.
//   clk, n_rst - clock and synchronous active-low reset
//   bus        - rx_ctrl_unit_if.slave (serial line, shift register and host signals)
module rx_ctrl_unit
  import rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = RX_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = RX_DATA_BITS
) (
  input logic           clk,
  input logic           n_rst,
  rx_ctrl_unit_if.slave bus
);

  rx_state_t state_q, state_d;

  logic sync_q, s_q, s_prev_q;
  logic start_edge;
  logic timer_en, timer_clr;
  logic strobe, frame_done, half_bit;
  logic load_buffer;
  logic data_ready_q, data_ready_d;
  logic framing_q, framing_d;
  logic overrun_q, overrun_d;

  // Two-flop synchronizer plus one history flop; idle level is 1 so reset
  // cannot fake a falling edge.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_q   <= 1'b1;
      s_q      <= 1'b1;
      s_prev_q <= 1'b1;
    end else begin
      sync_q   <= bus.serial_in;
      s_q      <= sync_q;
      s_prev_q <= s_q;
    end
  end

  assign start_edge = s_prev_q & ~s_q;

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS)
  ) u_bit_timer (
    .clk         (clk),
    .n_rst       (n_rst),
    .enable      (timer_en),
    .clear       (timer_clr),
    .shift_strobe(strobe),
    .frame_done  (frame_done),
    .half_bit    (half_bit)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start_edge) state_d = START_CHK;
      // Line back high at mid start bit means a glitch, not a frame.
      START_CHK: if (half_bit) state_d = s_q ? IDLE : RECV;
      RECV:      if (frame_done) state_d = STOP_CHK;
      STOP_CHK:  state_d = bus.stop_bit ? LOAD : IDLE;
      LOAD:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state only
  always_comb begin
    timer_en    = 1'b0;
    timer_clr   = 1'b1;
    load_buffer = 1'b0;
    unique case (state_q)
      START_CHK: begin
        timer_en  = 1'b1;
        // Restart timing from the start-bit midpoint for the data bits.
        timer_clr = half_bit;
      end
      RECV: begin
        timer_en  = 1'b1;
        timer_clr = 1'b0;
      end
      LOAD:    load_buffer = 1'b1;
      default: ;
    endcase
  end

  // Status flags. A load wins over a coincident read so the new byte stays
  // visible; a coincident read also suppresses the overrun.
  always_comb begin
    framing_d    = framing_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;

    if (state_q == IDLE && start_edge) begin
      framing_d = 1'b0;
    end else if (state_q == STOP_CHK && !bus.stop_bit) begin
      framing_d = 1'b1;
    end

    if (state_q == LOAD) begin
      data_ready_d = 1'b1;
    end else if (bus.data_read) begin
      data_ready_d = 1'b0;
    end

    if (state_q == LOAD && data_ready_q && !bus.data_read) begin
      overrun_d = 1'b1;
    end else if (bus.data_read) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      framing_q    <= 1'b0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      framing_q    <= framing_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.shift_strobe  = strobe;
  assign bus.load_buffer   = load_buffer;
  assign bus.data_ready    = data_ready_q;
  assign bus.framing_error = framing_q;
  assign bus.overrun_error = overrun_q;

endmodule

// File: tb/tb_rx_ctrl_unit.sv
// tb_rx_ctrl_unit: directed self-checking bench for rx_ctrl_unit
// (10 clocks per bit, 8 data bits).
module tb_rx_ctrl_unit;

  localparam int Cpb       = 10;
  // Cycle offsets from the clock cycle in which the line is driven low:
  // start_edge appears 2 cycles later, first strobe 15 after that, load at 97.
  localparam int StrobeOff = 17;
  localparam int LoadOff   = 99;
  localparam int AbortC    = 48;  // just after the 4th strobe (offset 47)
  localparam int Gap       = 5;

  logic clk = 1'b0;
  logic n_rst;
  int   cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  int strobe_q[$];
  int load_q[$];
  int dr_rise_q[$];
  int both_n = 0;
  logic dr_prev = 1'b0;

  int   s0, l0, r0;
  int   frame_fall;
  logic mid_fe;

  rx_ctrl_unit_if bus ();

  rx_ctrl_unit #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (8)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.shift_strobe === 1'b1) strobe_q.push_back(cyc);
    if (bus.load_buffer === 1'b1) load_q.push_back(cyc);
    if (bus.data_ready === 1'b1 && dr_prev !== 1'b1) dr_rise_q.push_back(cyc);
    if (bus.shift_strobe === 1'b1 && bus.load_buffer === 1'b1) both_n++;
    dr_prev = bus.data_ready;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic dr, input logic fe, input logic oe);
    check_eq({tag, "_strobe"}, {31'd0, bus.shift_strobe}, 32'd0);
    check_eq({tag, "_load"}, {31'd0, bus.load_buffer}, 32'd0);
    check_eq({tag, "_data_ready"}, {31'd0, bus.data_ready}, {31'd0, dr});
    check_eq({tag, "_framing"}, {31'd0, bus.framing_error}, {31'd0, fe});
    check_eq({tag, "_overrun"}, {31'd0, bus.overrun_error}, {31'd0, oe});
  endtask

  // Drives one 10-bit frame (start, data LSB first, stop) starting at a negedge.
  task automatic send_frame(input logic [7:0] data, input bit rd_at_load, input int abort_c);
    logic [9:0] fr;
    fr = {1'b1, data, 1'b0};
    frame_fall = cyc;
    for (int c = 0; c < 10 * Cpb; c++) begin
      if (c == abort_c) begin
        n_rst = 1'b0;
        bus.serial_in = 1'b1;
        @(negedge clk);
        check_outputs("abort_rst", 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        break;
      end
      if (c != 0 && (c % Cpb) == 0) fr = fr >> 1;
      bus.serial_in = fr[0];
      bus.data_read = rd_at_load && (c == LoadOff);
      if (c == 2 * Cpb) mid_fe = bus.framing_error;
      @(negedge clk);
    end
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    repeat (Gap) @(negedge clk);
  endtask

  task automatic mark();
    s0 = strobe_q.size();
    l0 = load_q.size();
    r0 = dr_rise_q.size();
  endtask

  initial begin
    n_rst         = 1'b0;
    bus.serial_in = 1'b0;
    bus.stop_bit  = 1'b1;
    bus.data_read = 1'b0;

    // Reset with the line low
    repeat (2) @(negedge clk);
    check_outputs("reset", 1'b0, 1'b0, 1'b0);
    bus.serial_in = 1'b1;
    @(negedge clk);
    n_rst = 1'b1;
    mark();
    repeat (50) @(negedge clk);
    check_eq("idle_no_strobe", strobe_q.size() - s0, 0);

    // Good frame 0xA5
    mark();
    send_frame(8'hA5, 1'b0, -1);
    check_eq("a5_strobes", strobe_q.size() - s0, 9);
    check_eq("a5_loads", load_q.size() - l0, 1);
    check_eq("a5_dr_rises", dr_rise_q.size() - r0, 1);
    if (strobe_q.size() - s0 == 9 && load_q.size() - l0 == 1 && dr_rise_q.size() - r0 == 1) begin
      check_eq("a5_first_strobe", strobe_q[s0] - frame_fall, StrobeOff);
      for (int i = 1; i < 9; i++) begin
        check_eq("a5_spacing", strobe_q[s0+i] - strobe_q[s0+i-1], Cpb);
      end
      check_eq("a5_load_cycle", load_q[l0] - frame_fall, LoadOff);
      check_eq("a5_load_after_strobe", load_q[l0] - strobe_q[s0+8], 2);
      check_eq("a5_dr_after_load", dr_rise_q[r0] - load_q[l0], 1);
    end
    check_eq("a5_framing", {31'd0, bus.framing_error}, 32'd0);
    check_eq("a5_overrun", {31'd0, bus.overrun_error}, 32'd0);

    // Glitch: 3 low cycles, data_ready must survive untouched
    mark();
    bus.serial_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.serial_in = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("glitch_strobes", strobe_q.size() - s0, 0);
    check_eq("glitch_loads", load_q.size() - l0, 0);
    check_outputs("glitch", 1'b1, 1'b0, 1'b0);

    bus.data_read = 1'b1;
    @(negedge clk);
    bus.data_read = 1'b0;
    check_eq("read_clears_dr", {31'd0, bus.data_ready}, 32'd0);

    // Framing error, then recovery on the next good frame
    mark();
    bus.stop_bit = 1'b0;
    send_frame(8'h3C, 1'b0, -1);
    bus.stop_bit = 1'b1;
    check_eq("fe_strobes", strobe_q.size() - s0, 9);
    check_eq("fe_loads", load_q.size() - l0, 0);
    check_eq("fe_flag", {31'd0, bus.framing_error}, 32'd1);
    check_eq("fe_dr", {31'd0, bus.data_ready}, 32'd0);
    mark();
    send_frame(8'h5A, 1'b0, -1);
    check_eq("fe_cleared_mid", {31'd0, mid_fe}, 32'd0);
    check_eq("rec_loads", load_q.size() - l0, 1);
    check_outputs("rec", 1'b1, 1'b0, 1'b0);

    // Overrun: second frame without a read
    send_frame(8'hFF, 1'b0, -1);
    check_outputs("ovr", 1'b1, 1'b0, 1'b1);
    bus.data_read = 1'b1;
    @(negedge clk);
    bus.data_read = 1'b0;
    check_outputs("ovr_read", 1'b0, 1'b0, 1'b0);

    // Read coincident with the second LOAD: no overrun, data stays ready
    send_frame(8'h01, 1'b0, -1);
    check_eq("coin_first_dr", {31'd0, bus.data_ready}, 32'd1);
    mark();
    send_frame(8'h80, 1'b1, -1);
    check_eq("coin_loads", load_q.size() - l0, 1);
    check_outputs("coin", 1'b1, 1'b0, 1'b0);

    // Reset after the 4th strobe, then a clean frame
    mark();
    send_frame(8'hC3, 1'b0, AbortC);
    repeat (100) @(negedge clk);
    check_eq("abort_strobes", strobe_q.size() - s0, 4);
    check_eq("abort_loads", load_q.size() - l0, 0);
    check_outputs("abort_idle", 1'b0, 1'b0, 1'b0);
    mark();
    send_frame(8'h96, 1'b0, -1);
    check_eq("post_strobes", strobe_q.size() - s0, 9);
    check_eq("post_loads", load_q.size() - l0, 1);
    check_outputs("post", 1'b1, 1'b0, 1'b0);

    check_eq("strobe_load_overlap", both_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/rx_ctrl_unit.md
# rx_ctrl_unit

Receive control unit for the UART receiver. It detects the start bit on the serial line, times each bit period, and issues mid-bit `shift_strobe` pulses to the 9-bit receive shift register (8 data bits plus stop bit). It checks the stop bit, loads the receive buffer, and maintains the `data_ready`, `framing_error` and `overrun_error` status flags for the host side.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit; must be even and ≥4.
- `DATA_BITS`, default 8: data bits per frame; total strobes per frame are `DATA_BITS+1`.
- `clk`  in  1  system clock, all logic on the rising edge.
- `n_rst`  in  1  reset, synchronous and active-low.
- `serial_in`  in  1  raw asynchronous serial line, idle high.
- `stop_bit`  in  1  stop-bit output of the shift register.
- `data_read`  in  1  host has consumed the buffer; one-cycle pulse.
- `shift_strobe`  out  1  one-cycle shift enable to the shift register.
- `load_buffer`  out  1  one-cycle pulse; copy `packet_data` into the receive buffer.
- `data_ready`  out  1  buffer holds unread data.
- `framing_error`  out  1  last frame had stop bit = 0.
- `overrun_error`  out  1  a frame was loaded while `data_ready` was still 1.

## Operation
- **Input conditioning**
  - `serial_in` passes through a 2-flop synchronizer to produce `s`.
  - `start_edge` = (previous `s`==1) && (`s`==0).
  - `start_edge` is evaluated only in IDLE.
- **FSM states:** IDLE, START_CHK, RECV, STOP_CHK, LOAD.
- **IDLE**
  - On `start_edge`: go to START_CHK, clear the timer, clear `framing_error`.
- **START_CHK**
  - The timer counts from 0.
  - At timer == `CLKS_PER_BIT/2-1`, sample `s`.
  - `s`==1 (glitch): return to IDLE with no other effect.
  - `s`==0: go to RECV, clear the timer and the bit counter.
- **RECV**
  - The timer counts 0..`CLKS_PER_BIT-1` and wraps to 0.
  - `shift_strobe`=1 during the cycle where timer == `CLKS_PER_BIT-1`.
  - The bit counter increments on each strobe.
  - The strobe that brings the bit counter to `DATA_BITS+1` moves the FSM to STOP_CHK.
- **STOP_CHK** (one cycle; `stop_bit` is valid here)
  - `stop_bit`==1: go to LOAD.
  - `stop_bit`==0: set `framing_error`, go to IDLE, no load.
- **LOAD** (one cycle)
  - `load_buffer`=1.
  - Next cycle: `data_ready`=1.
  - If `data_ready` was already 1 and `data_read` is not asserted this cycle, set `overrun_error`.
  - Then go to IDLE.
- **Status flags**
  - `data_read` clears `data_ready` and `overrun_error` on the next edge.
  - `data_read` in the same cycle as LOAD: `data_ready` stays 1 and `overrun_error` is not set.
  - `framing_error` holds until the next valid start edge.
- **Outputs:** `shift_strobe` and `load_buffer` are decoded from registered state and timer, so they are glitch-free and never asserted together.
- **Widths:** timer is `$clog2(CLKS_PER_BIT)` bits; bit counter is `$clog2(DATA_BITS+2)` bits.

## Timing
- **Reset:** `n_rst`==0 at a rising edge drives the following values after that edge:
  - FSM to IDLE;
  - timer and bit counter to 0;
  - all outputs to 0;
  - synchronizer flops to 1.
- **Reset mid-frame** aborts the frame with no strobe, no load and no flag change other than clearing.
- **Frame latency** (cycle 0 = cycle `start_edge` is high in IDLE, `CLKS_PER_BIT`=10, `DATA_BITS`=8):
  - start sample at cycle 5;
  - strobes at cycles 15, 25, …, 95 (9 strobes, each mid-bit);
  - STOP_CHK at cycle 96;
  - `load_buffer` at cycle 97;
  - `data_ready` high from cycle 98.
- **Synchronizer delay:** cycle 0 is 2–3 clocks after the line's falling edge.
- **Serial activity outside IDLE:** `serial_in` transitions during START_CHK through LOAD never restart the frame.
- **Back-to-back frames:** the next start edge is accepted in the first IDLE cycle after LOAD or STOP_CHK.

## Structure
- Package `rx_pkg`:
  - `rx_state_t` enum (IDLE, START_CHK, RECV, STOP_CHK, LOAD);
  - default constants `RX_CLKS_PER_BIT`=10 and `RX_DATA_BITS`=8.
- Sub-module `rx_bit_timer`:
  - contains the timer and bit counter;
  - inputs: `clk`, `n_rst`, `enable`, `clear`;
  - outputs: `shift_strobe`, `frame_done`;
  - parameters: `CLKS_PER_BIT`, `DATA_BITS`.
- The FSM, synchronizer and flag logic live in `rx_ctrl_unit`.

## Test plan
- **Reset:** hold `n_rst`=0 for 2 cycles with `serial_in`=0 → all outputs 0. After release with the line idle high, no strobe for 50 cycles.
- **Valid frame 0xA5**, stop bit=1, 10 clk/bit → exactly 9 strobes spaced 10 cycles apart at mid-bit. `load_buffer` 2 cycles after the 9th strobe, then `data_ready`=1 and `framing_error`=0.
- **Glitch:** line low for 3 cycles then high → return to IDLE with 0 strobes and no flag change.
- **Framing error:** stop bit=0 → 9 strobes, no `load_buffer`, `framing_error`=1. The next valid start edge clears it and the next good frame loads.
- **Overrun:** two good frames with no `data_read` → `overrun_error`=1 after the second LOAD. A `data_read` pulse clears both flags. A repeat with `data_read` coincident with LOAD → `overrun_error` stays 0.
- **Reset mid-frame:** assert `n_rst`=0 after the 4th strobe → idle outputs on the next edge. The following full frame receives correctly with 9 strobes.
